// File: rtl/mix_pkg.sv
// Shared state encoding and gain constants for the wet/dry mix sequencer.
// Gain constants are functions of the fraction width so every instance agrees.
package mix_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WET,
        MIX
    } mix_state_t;

    localparam int unsigned MIX_GAIN_W_DEFAULT = 8;

    function automatic int unsigned unity_gain(input int unsigned gain_w);
        return 32'd1 << gain_w;
    endfunction

    function automatic int unsigned default_gain(input int unsigned gain_w);
        return 32'd1 << (gain_w - 1);
    endfunction

endpackage

// File: rtl/mix_gain_ramp.sv
// Wet-gain register: clamps the requested target to unity and moves the
// current gain one step toward it on each enable pulse.
module mix_gain_ramp
    import mix_pkg::*;
#(
    parameter int unsigned GAIN_W = MIX_GAIN_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            step_en,
    input  logic [GAIN_W:0] target,
    output logic [GAIN_W:0] gain
);

    localparam logic [GAIN_W:0] UNITY      = (GAIN_W + 1)'(unity_gain(GAIN_W));
    localparam logic [GAIN_W:0] RESET_GAIN = (GAIN_W + 1)'(default_gain(GAIN_W));
    localparam logic [GAIN_W:0] ONE        = (GAIN_W + 1)'(1);

    logic [GAIN_W:0] gain_q;
    logic [GAIN_W:0] gain_d;
    logic [GAIN_W:0] target_clamped;

    always_comb begin
        target_clamped = (target > UNITY) ? UNITY : target;
        gain_d         = gain_q;
        if (step_en) begin
            if (gain_q < target_clamped) begin
                gain_d = gain_q + ONE;
            end else if (gain_q > target_clamped) begin
                gain_d = gain_q - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gain_q <= RESET_GAIN;
        end else begin
            gain_q <= gain_d;
        end
    end

    assign gain = gain_q;

endmodule

// File: rtl/mix_sequencer.sv
// Per-sample wet/dry mix controller: latches the dry sample, fetches a wet
// sample (with timeout fallback to the previous wet), and emits the weighted mix.
module mix_sequencer
    import mix_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned GAIN_W  = MIX_GAIN_W_DEFAULT,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             sampleStrobe_i,
    input  logic [WIDTH-1:0] pktDry_i,
    output logic             wetReq_o,
    input  logic [WIDTH-1:0] pktWet_i,
    input  logic             wetValid_i,
    input  logic [GAIN_W:0]  mixTarget_i,
    output logic [WIDTH-1:0] pktMixed_o,
    output logic             mixValid_o,
    output logic             busy_o,
    output logic             timeoutErr_o,
    output logic             overrun_o
);

    localparam int unsigned       PROD_W   = WIDTH + GAIN_W + 2;
    localparam int unsigned       CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [GAIN_W:0]   UNITY    = (GAIN_W + 1)'(unity_gain(GAIN_W));

    mix_state_t       state_q, state_d;
    logic [WIDTH-1:0] dry_q, dry_d;
    logic [WIDTH-1:0] wet_q, wet_d;
    logic [WIDTH-1:0] prev_wet_q, prev_wet_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mixed_q, mixed_d;
    logic             mix_valid_q, mix_valid_d;
    logic             wet_req_q, wet_req_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic [GAIN_W:0]  gain;

    mix_gain_ramp #(
        .GAIN_W (GAIN_W)
    ) u_gain_ramp (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .step_en (state_q == MIX),
        .target  (mixTarget_i),
        .gain    (gain)
    );

    // Weights are zero-extended so the signed products stay exact; the sum of
    // weights is unity, so the floor-shifted result always fits WIDTH.
    logic signed [PROD_W-1:0] dry_ext, wet_ext, dry_wt, wet_wt, acc;
    logic [WIDTH-1:0]         mix_res;

    always_comb begin
        dry_ext = {{(PROD_W - WIDTH){dry_q[WIDTH-1]}}, dry_q};
        wet_ext = {{(PROD_W - WIDTH){wet_q[WIDTH-1]}}, wet_q};
        dry_wt  = {{(PROD_W - GAIN_W - 1){1'b0}}, UNITY - gain};
        wet_wt  = {{(PROD_W - GAIN_W - 1){1'b0}}, gain};
        acc     = dry_ext * dry_wt + wet_ext * wet_wt;
        mix_res = WIDTH'(acc >>> GAIN_W);
    end

    always_comb begin
        state_d     = state_q;
        dry_d       = dry_q;
        wet_d       = wet_q;
        prev_wet_d  = prev_wet_q;
        cnt_d       = cnt_q;
        mixed_d     = mixed_q;
        mix_valid_d = 1'b0;
        wet_req_d   = 1'b0;
        timeout_d   = 1'b0;
        overrun_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sampleStrobe_i) begin
                    dry_d     = pktDry_i;
                    wet_req_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_WET;
                end
            end
            WAIT_WET: begin
                cnt_d     = cnt_q + CNT_ONE;
                overrun_d = sampleStrobe_i;
                if (wetValid_i) begin
                    wet_d      = pktWet_i;
                    prev_wet_d = pktWet_i;
                    state_d    = MIX;
                end else if (cnt_q == CNT_LAST) begin
                    wet_d     = prev_wet_q;
                    timeout_d = 1'b1;
                    state_d   = MIX;
                end
            end
            MIX: begin
                mixed_d     = mix_res;
                mix_valid_d = 1'b1;
                overrun_d   = sampleStrobe_i;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            dry_q       <= '0;
            wet_q       <= '0;
            prev_wet_q  <= '0;
            cnt_q       <= '0;
            mixed_q     <= '0;
            mix_valid_q <= 1'b0;
            wet_req_q   <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dry_q       <= dry_d;
            wet_q       <= wet_d;
            prev_wet_q  <= prev_wet_d;
            cnt_q       <= cnt_d;
            mixed_q     <= mixed_d;
            mix_valid_q <= mix_valid_d;
            wet_req_q   <= wet_req_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
        end
    end

    assign wetReq_o     = wet_req_q;
    assign pktMixed_o   = mixed_q;
    assign mixValid_o   = mix_valid_q;
    assign busy_o       = (state_q != IDLE);
    assign timeoutErr_o = timeout_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_mix_sequencer.sv
// Self-checking bench for mix_sequencer: a transaction-level model schedules
// the expected output events per cycle and a single process compares them.
module tb_mix_sequencer;

    localparam int unsigned W  = 16;
    localparam int unsigned GW = 8;
    localparam int unsigned TO = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          strobe;
    logic [W-1:0]  pkt_dry;
    logic          wet_req;
    logic [W-1:0]  pkt_wet;
    logic          wet_valid;
    logic [GW:0]   mix_target;
    logic [W-1:0]  pkt_mixed;
    logic          mix_valid;
    logic          busy;
    logic          timeout_err;
    logic          overrun;

    mix_sequencer #(
        .WIDTH   (W),
        .GAIN_W  (GW),
        .TIMEOUT (TO)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .sampleStrobe_i (strobe),
        .pktDry_i       (pkt_dry),
        .wetReq_o       (wet_req),
        .pktWet_i       (pkt_wet),
        .wetValid_i     (wet_valid),
        .mixTarget_i    (mix_target),
        .pktMixed_o     (pkt_mixed),
        .mixValid_o     (mix_valid),
        .busy_o         (busy),
        .timeoutErr_o   (timeout_err),
        .overrun_o      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Expected events keyed by cycle number; absent key means the output is 0.
    bit           exp_req   [int];
    bit           exp_valid [int];
    bit           exp_to    [int];
    bit           exp_ovr   [int];
    bit           exp_busy  [int];
    logic [W-1:0] hold_from [int];
    logic [W-1:0] exp_hold = '0;

    // Model state: current wet gain and last accepted wet sample.
    int           g_m = 1 << (GW - 1);
    logic [W-1:0] prev_wet_m = '0;

    task automatic check_lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", nm, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (hold_from.exists(cyc)) exp_hold = hold_from[cyc];
            check_lit("wetReq_o",     32'(wet_req),     32'(exp_req.exists(cyc)));
            check_lit("mixValid_o",   32'(mix_valid),   32'(exp_valid.exists(cyc)));
            check_lit("timeoutErr_o", 32'(timeout_err), 32'(exp_to.exists(cyc)));
            check_lit("overrun_o",    32'(overrun),     32'(exp_ovr.exists(cyc)));
            check_lit("busy_o",       32'(busy),        32'(exp_busy.exists(cyc)));
            check_lit("pktMixed_o",   32'(pkt_mixed),   32'(exp_hold));
        end
    end

    // Floor of the weighted average, done with plain integer division.
    function automatic logic [W-1:0] model_mix(input logic [W-1:0] d, input logic [W-1:0] w, input int g);
        longint n, q;
        n = longint'($signed(d)) * ((1 << GW) - g) + longint'($signed(w)) * g;
        q = n / (1 << GW);
        if (n < 0 && (n % (1 << GW)) != 0) q = q - 1;
        return q[W-1:0];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            strobe    = 1'b0;
            pkt_dry   = W'($urandom);
            wet_valid = 1'($urandom);
            pkt_wet   = W'($urandom);
        end
    endtask

    // One sample: strobe now; vdelay = cycles after strobe at which the wet
    // sample is valid (0 = never). tgt_b is driven from the mix cycle onward.
    task automatic run_sample(input logic [W-1:0] dry, input logic [W-1:0] wet, input int vdelay,
                              input logic [GW:0] tgt_a, input logic [GW:0] tgt_b,
                              input int ovr_off, input logic [W-1:0] ovr_dry, output int c_out);
        int c, decide, mixc, t;
        logic [W-1:0] wet_used;
        next_cycle();
        c          = cyc;
        c_out      = c;
        strobe     = 1'b1;
        pkt_dry    = dry;
        wet_valid  = 1'b0;
        pkt_wet    = W'($urandom);
        mix_target = tgt_a;

        decide = (vdelay > 0) ? c + vdelay : c + TO;
        mixc   = decide + 1;
        exp_req[c + 1] = 1'b1;
        for (int k = c + 1; k <= mixc; k++) exp_busy[k] = 1'b1;
        exp_valid[mixc + 1] = 1'b1;
        if (vdelay > 0) begin
            wet_used   = wet;
            prev_wet_m = wet;
        end else begin
            wet_used     = prev_wet_m;
            exp_to[mixc] = 1'b1;
        end
        if (ovr_off > 0) exp_ovr[c + ovr_off + 1] = 1'b1;
        hold_from[mixc + 1] = model_mix(dry, wet_used, g_m);
        t = (int'(tgt_b) > (1 << GW)) ? (1 << GW) : int'(tgt_b);
        if (g_m < t) g_m++;
        else if (g_m > t) g_m--;

        for (int k = c + 1; k <= mixc; k++) begin
            next_cycle();
            strobe     = (k == c + ovr_off);
            pkt_dry    = strobe ? ovr_dry : W'($urandom);
            wet_valid  = ((k == decide) && (vdelay > 0)) || ((k == mixc) && 1'($urandom));
            pkt_wet    = (k == decide) ? wet : W'($urandom);
            mix_target = (k >= mixc) ? tgt_b : tgt_a;
        end
    endtask

    // Consumes the cycle after the mix and checks the published value there.
    task automatic mix_out_check(input string nm, input logic [W-1:0] expv);
        idle_cycles(1);
        @(negedge clk);
        check_lit({nm, " valid"}, 32'(mix_valid), 32'd1);
        check_lit(nm, 32'(pkt_mixed), 32'(expv));
    endtask

    function automatic logic [W-1:0] pick_sample();
        int sel;
        sel = $urandom_range(5, 0);
        if (sel == 0) return 16'h8000;
        if (sel == 1) return 16'h7FFF;
        return W'($urandom);
    endfunction

    initial begin
        int c;
        rst_n      = 1'b0;
        strobe     = 1'b0;
        pkt_dry    = '0;
        pkt_wet    = '0;
        wet_valid  = 1'b0;
        mix_target = 9'd128;
        repeat (3) next_cycle();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check_lit("reset pktMixed_o", 32'(pkt_mixed), 32'd0);
        check_lit("reset busy_o", 32'(busy), 32'd0);

        // Baseline mix and latency.
        run_sample(16'h4000, 16'h2000, 3, 9'd128, 9'd128, 0, '0, c);
        mix_out_check("baseline mix", 16'h3000);
        check_lit("baseline latency", 32'(cyc - c), 32'd5);

        // Negative rounding is floor.
        run_sample(16'h8000, 16'h7FFF, 2, 9'd128, 9'd128, 0, '0, c);
        mix_out_check("floor rounding", 16'hFFFF);

        // Timeout reuses the previous wet; valid on the last cycle wins.
        run_sample(16'h1234, 16'h2000, 1, 9'd128, 9'd128, 0, '0, c);
        idle_cycles(1);
        run_sample(16'h0000, 16'hAAAA, 0, 9'd128, 9'd128, 0, '0, c);
        mix_out_check("timeout uses prev wet", 16'h1000);
        run_sample(16'h0000, 16'h0600, TO, 9'd128, 9'd128, 0, '0, c);
        mix_out_check("valid on timeout cycle", 16'h0300);

        // Overrun keeps the original dry sample.
        run_sample(16'h2222, 16'h2222, 3, 9'd128, 9'd200, 1, 16'h1111, c);
        mix_out_check("overrun keeps dry", 16'h2222);

        // Reset in WAIT_WET abandons the sample and restores gain/prevWet.
        next_cycle();
        c         = cyc;
        strobe    = 1'b1;
        pkt_dry   = 16'h3333;
        wet_valid = 1'b0;
        exp_req[c + 1] = 1'b1;
        for (int k = 1; k <= 3; k++) exp_busy[c + k] = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            next_cycle();
            strobe    = 1'b0;
            wet_valid = 1'b0;
        end
        next_cycle();
        rst_n     = 1'b0;
        wet_valid = 1'b1;
        pkt_wet   = 16'h5555;
        hold_from[c + 4] = '0;
        g_m        = 1 << (GW - 1);
        prev_wet_m = '0;
        next_cycle();
        rst_n     = 1'b1;
        wet_valid = 1'b0;
        @(negedge clk);
        check_lit("reset mid-op pktMixed_o", 32'(pkt_mixed), 32'd0);
        run_sample(16'h0100, 16'h7777, 0, 9'd128, 9'd128, 0, '0, c);
        mix_out_check("post-reset gain and prevWet", 16'h0080);

        // Ramp up to unity, then down to zero.
        for (int s = 1; s <= 129; s++) begin
            run_sample(16'h1000, 16'h0400, 1, 9'd256, 9'd256, 0, '0, c);
            if (s == 129) mix_out_check("ramp reaches wet", 16'h0400);
        end
        for (int s = 1; s <= 257; s++) begin
            run_sample(16'h1000, 16'h0400, 1, 9'd0, 9'd0, 0, '0, c);
            if (s == 257) mix_out_check("ramp reaches dry", 16'h1000);
        end

        // Randomized traffic: targets beyond unity, overruns, timeouts.
        for (int s = 0; s < 80; s++) begin
            int sel, vd, span, ovo;
            sel  = $urandom_range(9, 0);
            vd   = (sel == 0) ? 0 : (sel == 1) ? TO : $urandom_range(6, 1);
            span = (vd == 0) ? TO + 1 : vd + 1;
            ovo  = ($urandom_range(9, 0) < 3) ? $urandom_range(span, 1) : 0;
            run_sample(pick_sample(), pick_sample(), vd, 9'($urandom_range(511, 0)),
                       9'($urandom_range(511, 0)), ovo, W'($urandom), c);
            idle_cycles($urandom_range(2, 0));
        end

        idle_cycles(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
